// File: rtl/sequenciador_pc_if.sv
// Request/status bundle between the control unit and the PC sequencer.
// The master drives the transfer requests; the slave returns PC and stack status.
interface sequenciador_pc_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned TGT_W  = 26,
  parameter int unsigned DEPTH  = 16
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              en;
  logic              jump;
  logic              branch;
  logic              cond;
  logic              call;
  logic              ret;
  logic              reg_sel;
  logic [TGT_W-1:0]  imm_tgt;
  logic [ADDR_W-1:0] reg_tgt;
  logic [ADDR_W-1:0] pc;
  logic [CNT_W-1:0]  depth;
  logic              empty;
  logic              full;
  logic              overflow;
  logic              underflow;

  modport master (
    output en, jump, branch, cond, call, ret, reg_sel, imm_tgt, reg_tgt,
    input  pc, depth, empty, full, overflow, underflow
  );

  modport slave (
    input  en, jump, branch, cond, call, ret, reg_sel, imm_tgt, reg_tgt,
    output pc, depth, empty, full, overflow, underflow
  );
endinterface

// File: rtl/sequenciador_pc.sv
// Program-counter sequencer: selects next PC (inc/jump/branch/call/ret) and
// keeps return addresses in a circular hardware stack with sticky fault flags.
module sequenciador_pc #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       TGT_W    = 26,
  parameter int unsigned       DEPTH    = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic              clk,
  input logic              rst,
  sequenciador_pc_if.slave bus
);
  localparam int unsigned      PTR_W    = $clog2(DEPTH);
  localparam int unsigned      CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_INC,
    OP_TGT,
    OP_PUSH,
    OP_PUSH_OVF,
    OP_POP,
    OP_POP_UFL
  } op_e;

  logic [ADDR_W-1:0] r_pc;
  logic [CNT_W-1:0]  r_depth;
  logic [PTR_W-1:0]  r_top;
  logic              r_empty;
  logic              r_full;
  logic              r_ovf;
  logic              r_ufl;
  logic [ADDR_W-1:0] r_stack [DEPTH];

  op_e               w_op;
  logic [ADDR_W-1:0] w_target;
  logic [ADDR_W-1:0] w_pc_inc;
  logic              w_stack_empty;
  logic              w_stack_full;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [CNT_W-1:0]  w_depth_nxt;
  logic [PTR_W-1:0]  w_top_nxt;
  logic              w_ovf_nxt;
  logic              w_ufl_nxt;
  logic              w_push;

  assign w_target      = bus.reg_sel ? bus.reg_tgt : ADDR_W'(bus.imm_tgt);
  assign w_pc_inc      = r_pc + ADDR_W'(1);
  assign w_stack_empty = (r_depth == '0);
  assign w_stack_full  = (r_depth == CNT_FULL);

  // Request priority: ret > call > jump > taken branch > increment.
  always_comb begin
    w_op = OP_HOLD;
    if (bus.en) begin
      if (bus.ret) begin
        w_op = w_stack_empty ? OP_POP_UFL : OP_POP;
      end else if (bus.call) begin
        w_op = w_stack_full ? OP_PUSH_OVF : OP_PUSH;
      end else if (bus.jump || (bus.branch && bus.cond)) begin
        w_op = OP_TGT;
      end else begin
        w_op = OP_INC;
      end
    end
  end

  // A push when full still advances top, so the oldest entry is overwritten.
  always_comb begin
    w_pc_nxt    = r_pc;
    w_depth_nxt = r_depth;
    w_top_nxt   = r_top;
    w_ovf_nxt   = r_ovf;
    w_ufl_nxt   = r_ufl;
    w_push      = 1'b0;
    unique case (w_op)
      OP_INC: w_pc_nxt = w_pc_inc;
      OP_TGT: w_pc_nxt = w_target;
      OP_PUSH: begin
        w_pc_nxt    = w_target;
        w_push      = 1'b1;
        w_top_nxt   = r_top + PTR_W'(1);
        w_depth_nxt = r_depth + CNT_W'(1);
      end
      OP_PUSH_OVF: begin
        w_pc_nxt  = w_target;
        w_push    = 1'b1;
        w_top_nxt = r_top + PTR_W'(1);
        w_ovf_nxt = 1'b1;
      end
      OP_POP: begin
        w_pc_nxt    = r_stack[r_top];
        w_top_nxt   = r_top - PTR_W'(1);
        w_depth_nxt = r_depth - CNT_W'(1);
      end
      OP_POP_UFL: begin
        w_pc_nxt  = w_pc_inc;
        w_ufl_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_depth <= '0;
      r_top   <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
      r_ovf   <= 1'b0;
      r_ufl   <= 1'b0;
    end else begin
      r_pc    <= w_pc_nxt;
      r_depth <= w_depth_nxt;
      r_top   <= w_top_nxt;
      r_empty <= (w_depth_nxt == '0);
      r_full  <= (w_depth_nxt == CNT_FULL);
      r_ovf   <= w_ovf_nxt;
      r_ufl   <= w_ufl_nxt;
    end
  end

  // Return-address storage; contents are irrelevant after reset.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_stack[w_top_nxt] <= w_pc_inc;
    end
  end

  assign bus.pc        = r_pc;
  assign bus.depth     = r_depth;
  assign bus.empty     = r_empty;
  assign bus.full      = r_full;
  assign bus.overflow  = r_ovf;
  assign bus.underflow = r_ufl;
endmodule
